adjust_fsm_n: RTL and testbench

//  Generalised time-set controller for the clock datapath: N adjustable fields (field 0 = seconds,

---
 rtl/adjust_fsm_n.sv | 145 ++++++++++++++
 tb/tb_adjust_fsm_n.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/adjust_fsm_n.sv
// Time-set controller: NORM/ADJ mode, field selection, clear/increment pulses with
// hold-to-repeat, blinking of the active field and inactivity timeout back to NORM.
module adjust_fsm_n #(
  parameter int NFIELD  = 3,
  parameter int CLR0    = 1,
  parameter int RPT_DLY = 1000,
  parameter int RPT_PER = 250,
  parameter int TOUT    = 60,
  parameter int CW      = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      SIG2HZ,
  input  logic                      MODE,
  input  logic                      SELECT,
  input  logic                      ADJUST,
  output logic                      ADJMODE,
  output logic [$clog2(NFIELD)-1:0] CURFIELD,
  output logic                      FIELDCLR,
  output logic [NFIELD-1:0]         FIELDINC,
  output logic [NFIELD-1:0]         FIELDON
);

  localparam int SW = $clog2(NFIELD);
  localparam int TW = (TOUT > 0) ? $clog2(TOUT + 1) : 1;
  localparam logic [SW-1:0] LASTSEL = SW'(NFIELD - 1);
  localparam logic [TW-1:0] TLIM    = TW'(TOUT);
  localparam logic [CW-1:0] DLY     = CW'(RPT_DLY);
  localparam logic [CW-1:0] PER     = CW'(RPT_PER);

  typedef enum logic {NORM, ADJ} state_t;

  state_t          state;
  logic [SW-1:0]   sel;
  logic [TW-1:0]   tcnt;
  logic [CW-1:0]   rcnt;
  logic            rpt_on;
  logic            rpt_per;
  logic            adj_d;
  logic            sig_d;

  logic              adj_rise;
  logic              sig_rise;
  logic              is_clr;
  logic              tout_hit;
  logic [NFIELD-1:0] sel_hot;
  logic [CW-1:0]     rcnt_nxt;
  logic [CW-1:0]     rpt_lim;

  assign adj_rise = ADJUST & ~adj_d;
  assign sig_rise = SIG2HZ & ~sig_d;
  assign is_clr   = (CLR0 != 0) && (sel == '0);
  assign tout_hit = (TOUT != 0) && (tcnt == TLIM) && !ADJUST;
  assign sel_hot  = {{(NFIELD-1){1'b0}}, 1'b1} << sel;
  assign rcnt_nxt = rcnt + 1'b1;
  assign rpt_lim  = rpt_per ? PER : DLY;

  // rpt_on is only armed by a fresh ADJUST press, so a key already held across
  // MODE/SELECT never auto-repeats until it is released and pressed again.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= NORM;
      sel      <= '0;
      tcnt     <= '0;
      rcnt     <= '0;
      rpt_on   <= 1'b0;
      rpt_per  <= 1'b0;
      adj_d    <= 1'b1;
      sig_d    <= 1'b0;
      FIELDCLR <= 1'b0;
      FIELDINC <= '0;
    end else begin
      adj_d    <= ADJUST;
      sig_d    <= SIG2HZ;
      FIELDCLR <= 1'b0;
      FIELDINC <= '0;
      case (state)
        NORM: begin
          sel     <= '0;
          tcnt    <= '0;
          rcnt    <= '0;
          rpt_on  <= 1'b0;
          rpt_per <= 1'b0;
          if (MODE) state <= ADJ;
        end
        ADJ: begin
          if (MODE) begin
            state  <= NORM;
            sel    <= '0;
            tcnt   <= '0;
            rcnt   <= '0;
            rpt_on <= 1'b0;
          end else if (SELECT) begin
            sel    <= (sel == '0) ? LASTSEL : sel - 1'b1;
            tcnt   <= '0;
            rcnt   <= '0;
            rpt_on <= 1'b0;
          end else if (tout_hit) begin
            state  <= NORM;
            sel    <= '0;
            tcnt   <= '0;
            rcnt   <= '0;
            rpt_on <= 1'b0;
          end else begin
            if (ADJUST)
              tcnt <= '0;
            else if (sig_rise && (TOUT != 0) && (tcnt != TLIM))
              tcnt <= tcnt + 1'b1;

            if (adj_rise) begin
              if (is_clr) FIELDCLR <= 1'b1;
              else        FIELDINC <= sel_hot;
              rcnt    <= '0;
              rpt_per <= 1'b0;
              rpt_on  <= !is_clr;
            end else if (!ADJUST) begin
              rcnt   <= '0;
              rpt_on <= 1'b0;
            end else if (rpt_on) begin
              if (rcnt_nxt == rpt_lim) begin
                FIELDINC <= sel_hot;
                rcnt     <= '0;
                rpt_per  <= 1'b1;
              end else begin
                rcnt <= rcnt_nxt;
              end
            end
          end
        end
        default: state <= NORM;
      endcase
    end
  end

  // Active field blanks during the high half of SIG2HZ unless ADJUST is held.
  always_comb begin
    FIELDON = '1;
    for (int i = 0; i < NFIELD; i++)
      FIELDON[i] = ~((state == ADJ) && (sel == SW'(i)) && SIG2HZ && !ADJUST);
  end

  assign ADJMODE  = (state == ADJ);
  assign CURFIELD = sel;

endmodule

// File: tb/tb_adjust_fsm_n.sv
// Bench for adjust_fsm_n: table of per-cycle vectors plus hand sequences, expected
// outputs queued when driven and compared 1 time unit after the following CLK edge.
module tb_adjust_fsm_n;

  typedef struct packed {
    logic       adjmode;
    logic [1:0] cur;
    logic       clr;
    logic [2:0] inc;
    logic [2:0] on;
  } exp_t;

  typedef struct {
    logic m;
    logic s;
    logic a;
    logic g;
    exp_t e;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       SIG2HZ = 1'b0;
  logic       MODE = 1'b0;
  logic       SELECT = 1'b0;
  logic       ADJUST = 1'b0;
  logic       ADJMODE;
  logic [1:0] CURFIELD;
  logic       FIELDCLR;
  logic [2:0] FIELDINC;
  logic [2:0] FIELDON;

  int checks = 0;
  int errors = 0;

  exp_t  sbq[$];
  string tagq[$];
  vec_t  tbl[$];
  exp_t  mon_e;
  string mon_t;

  adjust_fsm_n #(
    .NFIELD(3), .CLR0(1), .RPT_DLY(10), .RPT_PER(4), .TOUT(4), .CW(8)
  ) dut (
    .CLK(CLK), .RST(RST), .SIG2HZ(SIG2HZ), .MODE(MODE), .SELECT(SELECT),
    .ADJUST(ADJUST), .ADJMODE(ADJMODE), .CURFIELD(CURFIELD),
    .FIELDCLR(FIELDCLR), .FIELDINC(FIELDINC), .FIELDON(FIELDON)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  function automatic exp_t ex(logic adj, logic [1:0] cur, logic clr,
                              logic [2:0] inc, logic [2:0] on);
    return {adj, cur, clr, inc, on};
  endfunction

  task automatic checkOutput(input string name, input exp_t e);
    exp_t act;
    act = {ADJMODE, CURFIELD, FIELDCLR, FIELDINC, FIELDON};
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL %s: got adj=%b cur=%0d clr=%b inc=%b on=%b, want adj=%b cur=%0d clr=%b inc=%b on=%b",
               name, act.adjmode, act.cur, act.clr, act.inc, act.on,
               e.adjmode, e.cur, e.clr, e.inc, e.on);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic s, input logic a,
                               input logic g, input exp_t e, input string tag);
    @(negedge CLK);
    MODE = m; SELECT = s; ADJUST = a; SIG2HZ = g;
    sbq.push_back(e);
    tagq.push_back(tag);
  endtask

  task automatic addVec(input logic m, input logic s, input logic a,
                        input logic g, input exp_t e);
    vec_t v;
    v.m = m; v.s = s; v.a = a; v.g = g; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic drain();
    @(posedge CLK);
    #2;
  endtask

  always @(posedge CLK) begin
    #1;
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      mon_t = tagq.pop_front();
      checkOutput(mon_t, mon_e);
    end
  end

  initial begin
    int pulses[6] = '{0, 10, 14, 18, 22, 26};
    logic hit;

    // reset state
    #12;
    checkOutput("reset", ex(0, 0, 0, 3'b000, 3'b111));
    @(negedge CLK);
    RST = 1'b1;

    // table: NORM ignores keys, field rotation, single taps, clear without repeat
    addVec(0, 0, 0, 0, ex(0, 0, 0, 3'b000, 3'b111));
    addVec(0, 1, 0, 0, ex(0, 0, 0, 3'b000, 3'b111));
    addVec(0, 0, 1, 0, ex(0, 0, 0, 3'b000, 3'b111));
    addVec(0, 0, 0, 0, ex(0, 0, 0, 3'b000, 3'b111));
    addVec(1, 0, 0, 0, ex(1, 0, 0, 3'b000, 3'b111));
    addVec(0, 1, 0, 0, ex(1, 2, 0, 3'b000, 3'b111));
    addVec(0, 1, 0, 0, ex(1, 1, 0, 3'b000, 3'b111));
    addVec(0, 1, 0, 0, ex(1, 0, 0, 3'b000, 3'b111));
    addVec(1, 0, 0, 0, ex(0, 0, 0, 3'b000, 3'b111));
    addVec(1, 0, 0, 0, ex(1, 0, 0, 3'b000, 3'b111));
    addVec(0, 1, 0, 0, ex(1, 2, 0, 3'b000, 3'b111));
    addVec(0, 1, 0, 0, ex(1, 1, 0, 3'b000, 3'b111));
    addVec(0, 0, 1, 0, ex(1, 1, 0, 3'b010, 3'b111));
    addVec(0, 0, 0, 0, ex(1, 1, 0, 3'b000, 3'b111));
    addVec(0, 1, 0, 0, ex(1, 0, 0, 3'b000, 3'b111));
    addVec(0, 0, 1, 0, ex(1, 0, 1, 3'b000, 3'b111));
    addVec(0, 0, 0, 0, ex(1, 0, 0, 3'b000, 3'b111));
    addVec(0, 0, 1, 0, ex(1, 0, 1, 3'b000, 3'b111));
    for (int i = 0; i < 12; i++)
      addVec(0, 0, 1, 0, ex(1, 0, 0, 3'b000, 3'b111));
    addVec(0, 0, 0, 0, ex(1, 0, 0, 3'b000, 3'b111));
    for (int i = 0; i < tbl.size(); i++)
      applyStimulus(tbl[i].m, tbl[i].s, tbl[i].a, tbl[i].g, tbl[i].e, $sformatf("tbl[%0d]", i));
    drain();

    // MODE beats ADJUST; key held across entry/SELECT needs a fresh press
    applyStimulus(0, 1, 0, 0, ex(1, 2, 0, 3'b000, 3'b111), "sel2");
    applyStimulus(1, 0, 1, 0, ex(0, 0, 0, 3'b000, 3'b111), "mode+adj");
    applyStimulus(0, 0, 1, 0, ex(0, 0, 0, 3'b000, 3'b111), "norm held");
    applyStimulus(1, 0, 1, 0, ex(1, 0, 0, 3'b000, 3'b111), "enter held");
    applyStimulus(0, 0, 1, 0, ex(1, 0, 0, 3'b000, 3'b111), "held after entry");
    applyStimulus(0, 1, 1, 0, ex(1, 2, 0, 3'b000, 3'b111), "select held");
    for (int i = 0; i < 12; i++)
      applyStimulus(0, 0, 1, 0, ex(1, 2, 0, 3'b000, 3'b111), "held after select");
    applyStimulus(0, 0, 0, 0, ex(1, 2, 0, 3'b000, 3'b111), "release");
    applyStimulus(0, 0, 1, 0, ex(1, 2, 0, 3'b100, 3'b111), "repress");
    applyStimulus(0, 0, 0, 0, ex(1, 2, 0, 3'b000, 3'b111), "release2");

    // auto-repeat on field 2: 30-cycle hold, then release
    for (int i = 0; i < 36; i++) begin
      hit = 1'b0;
      foreach (pulses[k]) if (pulses[k] == i) hit = 1'b1;
      applyStimulus(0, 0, (i < 30), 0,
                    ex(1, 2, 0, hit ? 3'b100 : 3'b000, 3'b111),
                    $sformatf("repeat+%0d", i + 1));
    end
    drain();

    // blink on field 1, then async reset in the cycle a repeat pulse is out
    applyStimulus(0, 1, 0, 0, ex(1, 1, 0, 3'b000, 3'b111), "sel1");
    applyStimulus(0, 0, 0, 1, ex(1, 1, 0, 3'b000, 3'b101), "blink off");
    applyStimulus(0, 0, 0, 0, ex(1, 1, 0, 3'b000, 3'b111), "blink on");
    applyStimulus(0, 0, 0, 1, ex(1, 1, 0, 3'b000, 3'b101), "blink off2");
    applyStimulus(0, 0, 1, 1, ex(1, 1, 0, 3'b010, 3'b111), "press steady");
    for (int i = 0; i < 9; i++)
      applyStimulus(0, 0, 1, 1, ex(1, 1, 0, 3'b000, 3'b111), "hold steady");
    applyStimulus(0, 0, 1, 1, ex(1, 1, 0, 3'b010, 3'b111), "first repeat");
    @(negedge CLK);
    ADJUST = 1'b0;
    #1;
    checkOutput("pre-reset blink", ex(1, 1, 0, 3'b010, 3'b101));
    RST = 1'b0;
    #1;
    checkOutput("async reset", ex(0, 0, 0, 3'b000, 3'b111));
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset held", ex(0, 0, 0, 3'b000, 3'b111));
    @(negedge CLK);
    SIG2HZ = 1'b0;
    RST = 1'b1;

    // timeout after 4 idle SIG2HZ rises; held ADJUST prevents it
    applyStimulus(1, 0, 0, 0, ex(1, 0, 0, 3'b000, 3'b111), "enter");
    for (int r = 1; r <= 4; r++) begin
      applyStimulus(0, 0, 0, 1, ex(1, 0, 0, 3'b000, 3'b110), $sformatf("tout rise%0d", r));
      applyStimulus(0, 0, 0, 0, ex((r < 4), 0, 0, 3'b000, 3'b111), $sformatf("tout fall%0d", r));
    end
    applyStimulus(1, 0, 0, 0, ex(1, 0, 0, 3'b000, 3'b111), "reenter");
    applyStimulus(0, 0, 1, 0, ex(1, 0, 1, 3'b000, 3'b111), "clr press");
    for (int r = 1; r <= 10; r++) begin
      applyStimulus(0, 0, 1, 1, ex(1, 0, 0, 3'b000, 3'b111), $sformatf("held rise%0d", r));
      applyStimulus(0, 0, 1, 0, ex(1, 0, 0, 3'b000, 3'b111), $sformatf("held fall%0d", r));
    end
    applyStimulus(0, 0, 0, 0, ex(1, 0, 0, 3'b000, 3'b111), "held release");
    for (int r = 1; r <= 3; r++) begin
      applyStimulus(0, 0, 0, 1, ex(1, 0, 0, 3'b000, 3'b110), $sformatf("idle rise%0d", r));
      applyStimulus(0, 0, 0, 0, ex(1, 0, 0, 3'b000, 3'b111), $sformatf("idle fall%0d", r));
    end
    applyStimulus(1, 0, 0, 0, ex(0, 0, 0, 3'b000, 3'b111), "exit");
    drain();

    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: %0d entries left, want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
